// File: rtl/bist_signature_checker.sv
// BIST session controller: seeds the SISA, runs P patterns plus a flush tail,
// then captures the final signature and compares it against the golden value.
module bist_signature_checker #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned FLUSH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [N-1:0]     golden,
    input  logic [N-1:0]     sig,
    output logic             sisa_init,
    output logic             gen_en,
    output logic             sisa_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N-1:0]     signature
);

    // FLUSH-1 must fit in the pattern counter; the counter is shared by RUN and FLUSH.
    localparam bit              HAS_FLUSH  = (FLUSH > 0);
    localparam int unsigned     FLUSH_LOAD = HAS_FLUSH ? FLUSH - 1 : 32'd0;
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_LOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   p_lat;
    logic [N-1:0]       golden_lat;

    // Outputs are loaded with the decode of the state being entered, so each one
    // is a flop that always equals its Moore value for the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            p_lat      <= '0;
            golden_lat <= '0;
            sisa_init  <= 1'b0;
            gen_en     <= 1'b0;
            sisa_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= '0;
        end else begin
            sisa_init <= 1'b0;
            gen_en    <= 1'b0;
            sisa_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!abort && start) begin
                        p_lat      <= pattern_count;
                        golden_lat <= golden;
                        state      <= S_INIT;
                        sisa_init  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_INIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        busy <= 1'b1;
                        if (p_lat != '0) begin
                            state   <= S_RUN;
                            cnt     <= p_lat - CNT_W'(1);
                            gen_en  <= 1'b1;
                            sisa_en <= 1'b1;
                        end else if (HAS_FLUSH) begin
                            state   <= S_FLUSH;
                            cnt     <= FLUSH_CNT;
                            sisa_en <= 1'b1;
                        end else begin
                            state <= S_COMPARE;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        busy <= 1'b1;
                        if (cnt != '0) begin
                            cnt     <= cnt - CNT_W'(1);
                            gen_en  <= 1'b1;
                            sisa_en <= 1'b1;
                        end else if (HAS_FLUSH) begin
                            state   <= S_FLUSH;
                            cnt     <= FLUSH_CNT;
                            sisa_en <= 1'b1;
                        end else begin
                            state <= S_COMPARE;
                        end
                    end
                end

                S_FLUSH: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        busy <= 1'b1;
                        if (cnt != '0) begin
                            cnt     <= cnt - CNT_W'(1);
                            sisa_en <= 1'b1;
                        end else begin
                            state <= S_COMPARE;
                        end
                    end
                end

                // All enables are low here, so sig is stable when captured.
                S_COMPARE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        state     <= S_DONE;
                        signature <= sig;
                        pass      <= (sig == golden_lat);
                        done      <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        p_lat      <= pattern_count;
                        golden_lat <= golden;
                        state      <= S_INIT;
                        sisa_init  <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        done <= 1'b1;
                        pass <= pass;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bist_signature_checker.md
Name: bist_signature_checker

Overview:
- BIST run controller and signature checker, directly downstream of the single-input signature analyzer (SISA).
- Sequences one test session:
  - reinitialises the SISA to its seed;
  - enables the pattern generator and the SISA for a programmed pattern count;
  - drains the CUT pipeline;
  - compares the final SISA signature against a golden value.
- Reports done/pass to the CPU-side control logic and holds the captured signature for readback.

Parameters:
- N, 8, signature width; must match SISA n.
- CNT_W, 16, width of pattern counter and pattern_count input.
- FLUSH, 2, extra SISA-enabled cycles after the last pattern to absorb CUT latency; 0 allowed.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin session; sampled only in IDLE and DONE.
- abort  input  1  cancel session; return to IDLE.
- pattern_count  input  CNT_W  number of patterns P; sampled when start is accepted.
- golden  input  N  expected signature; sampled when start is accepted.
- sig  input  N  SISA data output.
- sisa_init  output  1  one-cycle pulse; drives SISA rst (seed reload).
- gen_en  output  1  pattern-generator advance enable.
- sisa_en  output  1  SISA en.
- busy  output  1  high in INIT, RUN, FLUSH, COMPARE.
- done  output  1  high in DONE.
- pass  output  1  valid while done; 1 iff signature == golden.
- signature  output  N  captured final signature.

Behaviour:
- Register all outputs. Decode them from the state register only (Moore); no combinational path from inputs to outputs.
- Reset values: state=IDLE, counter=0, every output 0, signature=0, latched golden=0, latched P=0.
- States:
  - IDLE. All enables 0. On start=1: latch pattern_count and golden, go to INIT.
  - INIT (1 cycle). sisa_init=1, gen_en=0, sisa_en=0. Next state:
    - P>0: RUN, counter loaded with P-1.
    - P=0 and FLUSH>0: FLUSH, counter loaded with FLUSH-1.
    - otherwise: COMPARE.
  - RUN (exactly P cycles). gen_en=1, sisa_en=1. Decrement counter each cycle. When counter=0: go to FLUSH (load FLUSH-1), or to COMPARE if FLUSH=0.
  - FLUSH (exactly FLUSH cycles). gen_en=0, sisa_en=1. Decrement; at 0 go to COMPARE.
  - COMPARE (1 cycle). All enables 0, so sig is stable. On exit edge: signature<=sig, pass<=(sig==latched golden). Go to DONE.
  - DONE. done=1. signature and pass held. start=1 begins a new session: latch inputs, go to INIT, clear done and pass.
- Counts:
  - sisa_en is high for exactly P+FLUSH consecutive cycles per session.
  - gen_en is high for exactly P cycles.
  - gen_en is never high while sisa_en is low.
- Latency: done is visible 2+P+FLUSH cycles after the edge that samples start.
- P = 2^CNT_W - 1 is legal; the counter must not wrap mid-run.
- start while busy: ignored; latched P and golden are unchanged.
- abort:
  - In INIT, RUN, FLUSH or COMPARE: next state IDLE, enables drop next cycle, done=0, pass=0, signature unchanged.
  - In IDLE or DONE: DONE goes to IDLE with done, pass cleared; IDLE stays IDLE.
  - abort and start in the same cycle: abort wins.
- rst mid-session: immediate return to reset values. sisa_init is not asserted by rst; system rst reaches the SISA separately.
- pass is 0 whenever done=0.

Test Plan:
- P=4, FLUSH=2; stub SISA returns 8'hA5 after run; golden=8'hA5, start pulse -> sisa_init 1 cycle, gen_en 4 cycles, sisa_en 6 cycles, done at start-edge+8, pass=1, signature=8'hA5.
- Same run with golden=8'hA4 -> done=1, pass=0, signature=8'hA5. Then start again with golden=8'hA5 -> done and pass drop during the session, then done=1, pass=1.
- P=0, FLUSH=0 -> INIT then COMPARE; gen_en and sisa_en never assert; done at start-edge+2.
- P=10; start re-pulsed at RUN cycle 3 with pattern_count=3 -> ignored, gen_en still high 10 cycles. Abort at RUN cycle 5 -> IDLE next cycle, done=0, gen_en and sisa_en low.
- rst asserted mid-FLUSH, asynchronously between edges -> all outputs 0 immediately. After release, start with P=1 completes normally.
- Real SISA (n=8, poly=8'h1D, seed=8'h01) with Sin from an LFSR for P=24 -> signature matches the bench reference model, pass=1 with golden=model value.
